// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the multiplexed 7-segment display path.
//   - state_t       : scan FSM states (GUARD = anodes off, DRIVE = digit lit)
//   - SEG_0..SEG_F  : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK     : all segments off
//   - DEFAULT_NUM_DIGITS : default number of multiplexed digits
package display_pkg;

  typedef enum logic {
    GUARD,
    DRIVE
  } state_t;

  localparam int unsigned DEFAULT_NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode
//   Combinational digit-to-glyph decoder for a common-anode display.
//   Ports:
//     i_digit : 4-bit digit value (0-9 decimal, 10-15 shown as A,b,C,d,E,F)
//     i_blank : 1 = force all segments off
//     o_seg_n : active-low segments {g,f,e,d,c,b,a}
module bcd_seg_decode
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'h0: o_seg_n = SEG_0;
        4'h1: o_seg_n = SEG_1;
        4'h2: o_seg_n = SEG_2;
        4'h3: o_seg_n = SEG_3;
        4'h4: o_seg_n = SEG_4;
        4'h5: o_seg_n = SEG_5;
        4'h6: o_seg_n = SEG_6;
        4'h7: o_seg_n = SEG_7;
        4'h8: o_seg_n = SEG_8;
        4'h9: o_seg_n = SEG_9;
        4'hA: o_seg_n = SEG_A;
        4'hB: o_seg_n = SEG_B;
        4'hC: o_seg_n = SEG_C;
        4'hD: o_seg_n = SEG_D;
        4'hE: o_seg_n = SEG_E;
        4'hF: o_seg_n = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner
//   Captures an 8-digit BCD word on an active-low load strobe and scans it
//   onto a time-multiplexed common-anode 7-segment display with leading-zero
//   blanking, an anodes-off guard interval at each slot start and 16-level
//   brightness PWM.
//   Ports:
//     clk, rstN  : clock, synchronous active-low reset
//     bcd_in     : unpacked digit array (index 0 = least significant)
//     load_n     : active-low capture strobe
//     blank_lz   : 1 = suppress leading zeros (captured with the digits)
//     brightness : duty = (brightness+1)/16 during DRIVE
//     seg_n      : active-low segments {g,f,e,d,c,b,a}, constant per slot
//     an_n       : active-low anode enables, one-hot-or-none
//     slot_idx   : digit currently scanned
module bcd_seg_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [3:0]                    bcd_in [NUM_DIGITS],
  input  logic                          load_n,
  input  logic                          blank_lz,
  input  logic [3:0]                    brightness,
  output logic [6:0]                    seg_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] slot_idx
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                r_state;
  logic [CW-1:0]         r_slot_cnt;
  logic [IW-1:0]         r_slot_idx;
  logic [3:0]            r_pwm_cnt;
  logic [6:0]            r_seg_n;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic [3:0]            r_shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_zmask;
  logic                  r_boot;

  logic                  w_boundary;
  state_t                w_nstate;
  logic [CW-1:0]         w_nslot_cnt;
  logic [IW-1:0]         w_nidx;
  logic [3:0]            w_npwm;
  logic [NUM_DIGITS-1:0] w_nan_n;
  logic [NUM_DIGITS-1:0] w_zmask_in;
  logic [3:0]            w_seg_digit;
  logic                  w_seg_blank;
  logic [6:0]            w_seg_glyph;

  // Next-cycle values; the output registers are loaded from these so that
  // an_n/seg_n always describe the cycle the counters are in.
  always_comb begin
    w_boundary  = (r_slot_cnt == SLOT_LAST);
    w_nslot_cnt = w_boundary ? '0 : r_slot_cnt + 1'b1;

    w_nstate = r_state;
    if (w_boundary) begin
      w_nstate = GUARD;
    end else if (r_state == GUARD && r_slot_cnt == GUARD_LAST) begin
      w_nstate = DRIVE;
    end

    w_nidx = r_slot_idx;
    if (w_boundary) begin
      w_nidx = (r_slot_idx == IDX_LAST) ? '0 : r_slot_idx + 1'b1;
    end

    // Counter starts at 0 on the first DRIVE cycle of a slot.
    w_npwm = (r_state == DRIVE && w_nstate == DRIVE) ? r_pwm_cnt + 1'b1 : '0;

    w_nan_n = '1;
    if (w_nstate == DRIVE && w_npwm <= brightness) begin
      w_nan_n[w_nidx] = 1'b0;
    end
  end

  // Leading-zero mask: digit i blanks only if it and every higher digit is 0.
  always_comb begin
    logic v_hi_zero;
    v_hi_zero  = 1'b1;
    w_zmask_in = '0;
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      v_hi_zero     = v_hi_zero && (bcd_in[i] == 4'd0);
      w_zmask_in[i] = blank_lz && v_hi_zero;
    end
  end

  // Glyph for the slot about to be entered, read from the pre-capture shadow.
  assign w_seg_digit = r_shadow[w_nidx];
  assign w_seg_blank = r_zmask[w_nidx];

  bcd_seg_decode u_decode (
    .i_digit (w_seg_digit),
    .i_blank (w_seg_blank),
    .o_seg_n (w_seg_glyph)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= GUARD;
      r_slot_cnt <= '0;
      r_slot_idx <= '0;
      r_pwm_cnt  <= '0;
      r_seg_n    <= SEG_BLANK;
      r_an_n     <= '1;
      r_zmask    <= '0;
      r_boot     <= 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_state    <= w_nstate;
      r_slot_cnt <= w_nslot_cnt;
      r_slot_idx <= w_nidx;
      r_pwm_cnt  <= w_npwm;
      r_an_n     <= w_nan_n;
      r_boot     <= 1'b0;
      // Reset leaves no slot-entry edge for the first slot, so the first
      // cycle out of reset loads the glyph once; afterwards only on entry.
      if (r_boot || w_boundary) begin
        r_seg_n <= w_seg_glyph;
      end
      if (!load_n) begin
        r_shadow <= bcd_in;
        r_zmask  <= w_zmask_in;
      end
    end
  end

  assign seg_n    = r_seg_n;
  assign an_n     = r_an_n;
  assign slot_idx = r_slot_idx;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
module tb_bcd_seg_scanner;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] bcd_in [8];
  logic       load_n;
  logic       blank_lz;
  logic [3:0] brightness;

  logic [6:0] seg_n,    seg_n_p;
  logic [7:0] an_n,     an_n_p;
  logic [2:0] slot_idx, slot_idx_p;

  int unsigned cyc;
  int          n_checks;
  int          n_errors;
  int          low;

  // Hand-computed glyphs per digit index 0..7
  localparam logic [6:0] G1 [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}; // 12345678
  localparam logic [6:0] G2 [8] = '{7'h40, 7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}; // 00000070 blanked
  localparam logic [6:0] G3 [8] = '{7'h79, 7'h40, 7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}; // ABCDEF01

  bcd_seg_scanner #(
    .NUM_DIGITS   (8),
    .SLOT_CYCLES  (8),
    .GUARD_CYCLES (2)
  ) u_dut (
    .clk        (clk),
    .rstN       (rstN),
    .bcd_in     (bcd_in),
    .load_n     (load_n),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .slot_idx   (slot_idx)
  );

  bcd_seg_scanner #(
    .NUM_DIGITS   (8),
    .SLOT_CYCLES  (40),
    .GUARD_CYCLES (2)
  ) u_dut_pwm (
    .clk        (clk),
    .rstN       (rstN),
    .bcd_in     (bcd_in),
    .load_n     (load_n),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .seg_n      (seg_n_p),
    .an_n       (an_n_p),
    .slot_idx   (slot_idx_p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_bcd(input logic [31:0] v);
    for (int i = 0; i < 8; i++) bcd_in[i] = v[4*i +: 4];
  endtask

  function automatic logic [7:0] exp_an(input int unsigned c, input int unsigned slot,
                                        input logic [3:0] br);
    int unsigned pos, idx, p;
    pos = c % slot;
    idx = (c / slot) % 8;
    if (pos < 2) return 8'hFF;
    p = (pos - 2) % 16;
    if (p <= 32'(br)) return ~(8'h01 << idx);
    return 8'hFF;
  endfunction

  task automatic chk_main(input logic [6:0] exp_seg);
    chk("an_n",     32'(an_n),     32'(exp_an(cyc, 8, 4'hF)));
    chk("slot_idx", 32'(slot_idx), (cyc / 8) % 8);
    chk("seg_n",    32'(seg_n),    32'(exp_seg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    rstN       = 1'b0;
    load_n     = 1'b1;
    blank_lz   = 1'b0;
    brightness = 4'hF;
    set_bcd(32'h0);

    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    chk("rst an_n",       32'(an_n),       32'hFF);
    chk("rst seg_n",      32'(seg_n),      32'h7F);
    chk("rst slot_idx",   32'(slot_idx),   32'h0);
    chk("rst pwm an_n",   32'(an_n_p),     32'hFF);
    chk("rst pwm seg_n",  32'(seg_n_p),    32'h7F);
    chk("rst pwm idx",    32'(slot_idx_p), 32'h0);
    rstN = 1'b1;

    // First full scan plus wrap: all digits "0"
    while (cyc < 76) begin tick(); chk_main(7'h40); end

    // Mid-slot load during slot 1: current slot keeps its glyph
    set_bcd(32'h12345678); load_n = 1'b0;
    tick(); load_n = 1'b1; chk_main(7'h40);
    while (cyc < 79)  begin tick(); chk_main(7'h40); end
    while (cyc < 143) begin tick(); chk_main(G1[(cyc / 8) % 8]); end

    // Load on the slot boundary (end of slot 1): slot 2 keeps the old glyph
    set_bcd(32'h00000070); blank_lz = 1'b1; load_n = 1'b0;
    tick(); load_n = 1'b1; chk_main(G1[2]);
    while (cyc < 151) begin tick(); chk_main(G1[2]); end
    while (cyc < 220) begin tick(); chk_main(G2[(cyc / 8) % 8]); end

    // Mid-slot load in slot 3
    set_bcd(32'hABCDEF01); blank_lz = 1'b0; load_n = 1'b0;
    tick(); load_n = 1'b1; chk_main(G2[3]);
    while (cyc < 223) begin tick(); chk_main(G2[3]); end
    while (cyc < 290) begin tick(); chk_main(G3[(cyc / 8) % 8]); end

    // Reset mid-DRIVE with a simultaneous load: capture is discarded
    set_bcd(32'h99999999); blank_lz = 1'b1; load_n = 1'b0; rstN = 1'b0;
    tick();
    cyc = 0;
    chk("rst2 an_n",     32'(an_n),     32'hFF);
    chk("rst2 seg_n",    32'(seg_n),    32'h7F);
    chk("rst2 slot_idx", 32'(slot_idx), 32'h0);
    rstN = 1'b1; load_n = 1'b1;
    while (cyc < 64) begin tick(); chk_main(7'h40); end

    // PWM at brightness 3 on the 40-cycle-slot instance, slot 2 (cycles 80..119)
    brightness = 4'd3;
    low = 0;
    while (cyc < 79) tick();
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("pwm an_n", 32'(an_n_p), 32'(exp_an(cyc, 40, 4'd3)));
      if (cyc >= 82 && cyc <= 97 && an_n_p != 8'hFF) low++;
    end
    chk("pwm idx", 32'(slot_idx_p), 32'h2);
    chk("pwm low count", 32'(low), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Downstream consumer of the binary-to-BCD converter. Captures an 8-digit BCD word on a one-cycle active-low load strobe and drives a time-multiplexed, common-anode 7-segment display. Features: leading-zero blanking, anti-ghosting guard interval and 16-level brightness PWM. Sits between the converter and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 8, number of multiplexed digits (index 0 = least significant)
- SLOT_CYCLES, 50000, clk cycles each digit is selected; minimum 8
- GUARD_CYCLES, 2, cycles at slot start with all anodes off; must be < SLOT_CYCLES
- clk  in  1  clock
- rstN  in  1  reset, synchronous, active-low
- bcd_in  in  [3:0] x NUM_DIGITS  unpacked digit array from converter
- load_n  in  1  active-low capture strobe; bcd_in valid in any cycle load_n==0
- blank_lz  in  1  1 = suppress leading zeros
- brightness  in  4  duty select, duty = (brightness+1)/16
- seg_n  out  7  {g,f,e,d,c,b,a}, active-low
- an_n  out  NUM_DIGITS  anode enables, active-low, one-hot-or-none
- slot_idx  out  $clog2(NUM_DIGITS)  digit currently scanned (debug/verification)

## Operation
- Capture: load_n==0 at edge → shadow[] <= bcd_in. Also zmask[] is computed from bcd_in and blank_lz. zmask[i]=1 iff blank_lz, i>0, and all digits i..NUM_DIGITS-1 are 0. Digit 0 is never blanked. Consecutive low cycles each capture.
- Decode (bcd_seg_decode): 0-9 standard glyphs; 10-15 → A,b,C,d,E,F. Blanked digit → seg_n=7'h7F.
- FSM states:
  - GUARD: an_n all 1; on entry, seg_n is registered from shadow[slot_idx]/zmask.
  - DRIVE: an_n[slot_idx]=0 when PWM-on, else all 1.
- Transitions: GUARD→DRIVE when slot_cnt==GUARD_CYCLES-1. DRIVE→GUARD when slot_cnt==SLOT_CYCLES-1; at that point slot_idx increments, wrapping NUM_DIGITS-1→0.
- slot_cnt counts 0..SLOT_CYCLES-1 continuously and resets to 0 at every slot boundary.
- PWM: 4-bit pwm_cnt free-runs while in DRIVE and clears on GUARD entry. PWM-on iff pwm_cnt <= brightness; brightness 15 = always on in DRIVE. brightness is sampled every cycle.
- seg_n is held constant for a whole slot. A load mid-slot takes effect at the next GUARD entry for each digit; no mid-slot glitch.
- Width rules: slot_cnt width is $clog2(SLOT_CYCLES); all compares are unsigned.

## Timing
- Reset values: an_n all 1, seg_n 7'h7F, slot_idx 0, slot_cnt 0, pwm_cnt 0, state GUARD, shadow all 0, zmask all 0.
- Reset mid-scan returns all of the above on the next edge, regardless of load_n.
- First slot after reset shows "0" on digit 0: seg_n=7'b1000000, registered at the first GUARD cycle.
- Capture latency: 1 cycle to shadow. Visible on digit i at the first GUARD entry of slot i after capture. Worst case: NUM_DIGITS*SLOT_CYCLES + 1 cycles.
- Anode low begins at cycle GUARD_CYCLES of a slot. Anodes are never low during the first GUARD_CYCLES cycles or across a slot boundary.
- Full refresh period: NUM_DIGITS*SLOT_CYCLES cycles.
- load_n low in the same cycle as a slot boundary: the boundary's seg_n uses the pre-capture shadow. The new value appears one full scan later for that digit.

## Structure
- display_pkg holds:
  - state_t enum {GUARD, DRIVE}
  - 7-bit glyph constants SEG_0..SEG_F and SEG_BLANK
  - NUM_DIGITS default
- Sub-module bcd_seg_decode: combinational; 4-bit digit + blank → 7-bit active-low segments.
- Top contains the shadow/zmask registers, slot/pwm counters, FSM and output registers.

## Test plan
- Reset, SLOT_CYCLES=8, GUARD_CYCLES=2, brightness=15. Required response:
  - an_n=8'hFF during cycles 0-1, then 8'hFE during cycles 2-7
  - seg_n=7'b1000000 during the slot
  - slot_idx steps 0..7 every 8 cycles and wraps to 0
- Load 12345678 (digit7=1 … digit0=8), blank_lz=0 → next scan shows digit0 seg_n=7'b0000000 and digit7 seg_n=7'b1111001.
- Load 00000070, blank_lz=1 → digits 7..2 seg_n=7'h7F with their anode still strobing; digit1=7 (7'b1111000); digit0=0 (7'b1000000).
- brightness=3, SLOT_CYCLES=40, GUARD_CYCLES=2 → in DRIVE, anode low for pwm_cnt 0-3 of each 16-cycle PWM period; exactly 4 low cycles per 16.
- Load pulse in the middle of slot 3 → slot 3's seg_n is unchanged until its next GUARD entry. Load coincident with a slot boundary → the old glyph is kept for that slot.
- Assert rstN=0 mid-DRIVE with load_n=0 → next edge gives an_n=FF, seg_n=7F, shadow=0; the captured value is discarded.
